l2_infer: RTL

- Upstream inference stage of the level-2 layer: 4 neurons, 2 input synapses.
- Keeps one decaying time-surface trace per synapse and, on each accepted input event, computes each neuron's potential (weights · traces).
- Selects a single winner against per-neuron thresholds and emits a one-hot spike, the captured timestamps and all four potentials.
- Its outputs drive the L2 training stage's spike, timestamp and potential inputs; weights and thresholds come back from that training stage.

---
 rtl/l2_infer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/l2_infer.sv
// Level-2 inference: two decaying synapse traces feed four neurons. An accepted event is
// evaluated in four steps (capture, multiply-accumulate, compare, fire), and one winner is emitted.
// Ports: i_clk, i_rst_n, i_event[1:0]; i_weights and i_thresholds come from training;
// o_spikeout (one-hot, registered), o_ts, o_lv, o_nowin, o_drop, o_busy.
module l2_infer #(
  parameter int p_width        = 9,
  parameter int p_decay_period = 16,
  parameter int p_spike_len    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_event,
  input  logic [8*p_width-1:0]       i_weights,
  input  logic [4*(2*p_width+1)-1:0] i_thresholds,
  output logic [3:0]                 o_spikeout,
  output logic [2*p_width-1:0]       o_ts,
  output logic [4*(2*p_width+1)-1:0] o_lv,
  output logic                       o_nowin,
  output logic                       o_drop,
  output logic                       o_busy
);
  localparam int PW = 2*p_width + 1;
  localparam int CW = (p_decay_period > 1) ? $clog2(p_decay_period) : 1;
  localparam int SW = $clog2(p_spike_len + 1);
  localparam logic [CW-1:0] PRESC_MAX = CW'(p_decay_period - 1);
  localparam logic [SW-1:0] SPK_LAST  = SW'(p_spike_len - 1);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MAC, S_CMP, S_FIRE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             presc_q;
  logic                      tick;
  logic [1:0][p_width-1:0]   trace_q;
  logic [p_width-1:0]        w1 [4];
  logic [p_width-1:0]        w2 [4];
  logic [PW-1:0]             thr [4];
  logic [PW-1:0]             pot_q [4];
  logic [SW-1:0]             spk_cnt_q;
  logic                      win_vld;
  logic [1:0]                win_idx;
  logic [PW-1:0]             best;

  for (genvar n = 0; n < 4; n++) begin : g_unpack
    assign w1[n]  = i_weights[(2*n)*p_width +: p_width];
    assign w2[n]  = i_weights[(2*n+1)*p_width +: p_width];
    assign thr[n] = i_thresholds[n*PW +: PW];
  end

  // The decay tick happens in the clock where the prescaler wraps.
  assign tick = (presc_q == PRESC_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) presc_q <= '0;
    else if (tick) presc_q <= '0;
    else presc_q <= presc_q + CW'(1);
  end

  // An event refresh wins over a same-clock decay, in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trace_q <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (i_event[j])
          trace_q[j] <= '1;
        else if (tick && trace_q[j] != '0)
          trace_q[j] <= trace_q[j] - p_width'(1);
      end
    end
  end

  // Winner search: strict '>' keeps the lowest index on ties.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    best    = '0;
    for (int n = 0; n < 4; n++) begin
      if (pot_q[n] >= thr[n] && (!win_vld || pot_q[n] > best)) begin
        win_vld = 1'b1;
        win_idx = 2'(n);
        best    = pot_q[n];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_event != 2'b00) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_MAC;
      S_MAC:     state_d = S_CMP;
      S_CMP:     state_d = win_vld ? S_FIRE : S_IDLE;
      S_FIRE:    if (spk_cnt_q == SPK_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  assign o_busy = (state_q != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ts       <= '0;
      o_lv       <= '0;
      o_spikeout <= '0;
      o_nowin    <= 1'b0;
      o_drop     <= 1'b0;
      spk_cnt_q  <= '0;
      for (int n = 0; n < 4; n++) pot_q[n] <= '0;
    end else begin
      o_nowin <= 1'b0;
      // Events seen outside IDLE only refresh traces; they are never queued.
      o_drop  <= (state_q != S_IDLE) && (i_event != 2'b00);
      case (state_q)
        S_CAPTURE: o_ts <= {trace_q[1], trace_q[0]};
        S_MAC: begin
          for (int n = 0; n < 4; n++)
            pot_q[n] <= PW'(w1[n]) * PW'(o_ts[p_width-1:0])
                      + PW'(w2[n]) * PW'(o_ts[2*p_width-1:p_width]);
        end
        S_CMP: begin
          for (int n = 0; n < 4; n++) o_lv[n*PW +: PW] <= pot_q[n];
          spk_cnt_q <= '0;
          if (win_vld) o_spikeout <= 4'b0001 << win_idx;
          else         o_nowin    <= 1'b1;
        end
        S_FIRE: begin
          if (spk_cnt_q == SPK_LAST) o_spikeout <= '0;
          else spk_cnt_q <= spk_cnt_q + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
